dmem_wait_responder: RTL and testbench

Memory-side responder for the core's load/store port. It accepts one request at a time through a valid/ready handshake and inserts a configurable number of wait states. It performs byte, halfword or word stores with lane masking, and returns sign- or zero-extended load data through a held response handshake. It replaces the zero-latency data memory when the pipeline is moved to a stall-capable memory interface, and models slow SRAM/peripheral timing for that pipeline.

---
 rtl/dmem_wait_responder.sv | 244 ++++++++++++++++++++++++
 tb/tb_dmem_wait_responder.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_wait_responder.sv
// dmem_wait_responder
// Memory-side responder for the core load/store port. It takes one request at
// a time over a valid/ready handshake and waits WAIT_CYCLES cycles. It then
// performs a byte/halfword/word store with lane masking, or a load with sign or
// zero extension. The result is held on the response handshake until taken.
//
// Optional feature macro: DMEM_RSP_ALIGN_CHECK_EN
//   defined   : misaligned halfword/word accesses are rejected with rsp_err.
//   undefined : misaligned accesses are forced aligned and raise no error.
//
// The backing array has no reset, so its contents survive rst_n.

module dmem_wait_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_wr,
    input  logic [2:0]  req_ctrl,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        busy
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);
    localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    localparam logic [2:0] CTRL_B  = 3'b000;
    localparam logic [2:0] CTRL_H  = 3'b001;
    localparam logic [2:0] CTRL_W  = 3'b010;
    localparam logic [2:0] CTRL_BU = 3'b100;
    localparam logic [2:0] CTRL_HU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic [3:0]  wait_cnt;
    logic        lat_wr;
    logic [2:0]  lat_ctrl;
    logic [31:0] lat_addr;
    logic [31:0] lat_wdata;

    logic        accept;
    logic        eval_now;
    logic        take;

    logic        ctrl_bad;
    logic        range_bad;
    logic        align_bad;
    logic        eval_err;
    logic [31:0] eval_rdata;

    logic [IDX_W-1:0] mem_idx;
    logic [31:0]      rd_word;
    logic [7:0]       rd_byte;
    logic [15:0]      rd_half;
    logic             mem_we;
    logic [3:0]       mem_be;
    logic [31:0]      mem_wdata;

    logic        req_ready_d;
    logic        rsp_valid_d;
    logic [31:0] rsp_rdata_d;
    logic        rsp_err_d;
    logic        busy_d;

    logic [31:0] mem [DEPTH_WORDS];

    // The response is evaluated on the first RESP cycle, before rsp_valid is raised
    assign accept   = (state == ST_IDLE) && req_ready && req_valid;
    assign eval_now = (state == ST_RESP) && !rsp_valid;
    assign take     = (state == ST_RESP) && rsp_valid && rsp_ready;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; a zero wait count skips straight to RESP
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    state_next = (WAIT_CYCLES > 0) ? ST_WAIT : ST_RESP;
                end
            end
            ST_WAIT: begin
                if (wait_cnt == 4'd0) begin
                    state_next = ST_RESP;
                end
            end
            ST_RESP: begin
                if (take) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Wait-state down-counter, loaded on acceptance
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt <= 4'd0;
        end else if (accept) begin
            wait_cnt <= WAIT_LOAD;
        end else if ((state == ST_WAIT) && (wait_cnt != 4'd0)) begin
            wait_cnt <= wait_cnt - 4'd1;
        end
    end

    // Capture the request fields at acceptance so later input changes are ignored
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lat_wr    <= 1'b0;
            lat_ctrl  <= 3'b000;
            lat_addr  <= 32'd0;
            lat_wdata <= 32'd0;
        end else if (accept) begin
            lat_wr    <= req_wr;
            lat_ctrl  <= req_ctrl;
            lat_addr  <= req_addr;
            lat_wdata <= req_wdata;
        end
    end

    assign mem_idx = lat_addr[IDX_W+1:2];
    assign rd_word = mem[mem_idx];

    // Request checking, lane selection for loads and lane masking for stores
    always_comb begin
        ctrl_bad  = (lat_ctrl == 3'b011) || (lat_ctrl == 3'b110) || (lat_ctrl == 3'b111) ||
                    (lat_wr && ((lat_ctrl == CTRL_BU) || (lat_ctrl == CTRL_HU)));
        range_bad = |lat_addr[31:IDX_W+2];
`ifdef DMEM_RSP_ALIGN_CHECK_EN
        align_bad = ((lat_ctrl[1:0] == 2'b01) && lat_addr[0]) ||
                    ((lat_ctrl[1:0] == 2'b10) && (lat_addr[1:0] != 2'b00));
`else
        align_bad = 1'b0;
`endif
        eval_err = ctrl_bad || range_bad || align_bad;

        rd_byte = rd_word[8*lat_addr[1:0] +: 8];
        rd_half = lat_addr[1] ? rd_word[31:16] : rd_word[15:0];

        eval_rdata = 32'd0;
        if (!eval_err && !lat_wr) begin
            case (lat_ctrl)
                CTRL_B:  eval_rdata = {{24{rd_byte[7]}}, rd_byte};
                CTRL_BU: eval_rdata = {24'd0, rd_byte};
                CTRL_H:  eval_rdata = {{16{rd_half[15]}}, rd_half};
                CTRL_HU: eval_rdata = {16'd0, rd_half};
                CTRL_W:  eval_rdata = rd_word;
                default: eval_rdata = 32'd0;
            endcase
        end

        mem_be    = 4'b0000;
        mem_wdata = lat_wdata;
        case (lat_ctrl)
            CTRL_B: begin
                mem_be    = 4'b0001 << lat_addr[1:0];
                mem_wdata = {4{lat_wdata[7:0]}};
            end
            CTRL_H: begin
                mem_be    = lat_addr[1] ? 4'b1100 : 4'b0011;
                mem_wdata = {2{lat_wdata[15:0]}};
            end
            CTRL_W: begin
                mem_be    = 4'b1111;
                mem_wdata = lat_wdata;
            end
            default: begin
                mem_be    = 4'b0000;
                mem_wdata = lat_wdata;
            end
        endcase

        mem_we = eval_now && lat_wr && !eval_err;
    end

    // Backing array write, committed on the same edge that raises rsp_valid
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < 4; i++) begin
                if (mem_be[i]) begin
                    mem[mem_idx][8*i +: 8] <= mem_wdata[8*i +: 8];
                end
            end
        end
    end

    // Output next values, derived from the next state so every output is registered
    always_comb begin
        req_ready_d = (state_next == ST_IDLE);
        busy_d      = (state_next != ST_IDLE);
        rsp_valid_d = (state_next == ST_RESP) && (rsp_valid || eval_now);
        rsp_rdata_d = rsp_rdata;
        rsp_err_d   = rsp_err;
        if (eval_now) begin
            rsp_rdata_d = eval_rdata;
            rsp_err_d   = eval_err;
        end else if (take) begin
            rsp_rdata_d = 32'd0;
            rsp_err_d   = 1'b0;
        end
    end

    // Output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_ready <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= 32'd0;
            rsp_err   <= 1'b0;
            busy      <= 1'b0;
        end else begin
            req_ready <= req_ready_d;
            rsp_valid <= rsp_valid_d;
            rsp_rdata <= rsp_rdata_d;
            rsp_err   <= rsp_err_d;
            busy      <= busy_d;
        end
    end

endmodule

// File: tb/tb_dmem_wait_responder.sv
// Testbench for dmem_wait_responder: table-driven request vectors with a
// scoreboard queue, plus hand-written backpressure and reset-abort sequences.
// Expectations follow DMEM_RSP_ALIGN_CHECK_EN when it is defined.

module tb_dmem_wait_responder;

    localparam int DEPTH = 1024;
    localparam int WAITS = 2;

    localparam logic [2:0] F_B  = 3'b000;
    localparam logic [2:0] F_H  = 3'b001;
    localparam logic [2:0] F_W  = 3'b010;
    localparam logic [2:0] F_BU = 3'b100;
    localparam logic [2:0] F_HU = 3'b101;

    typedef struct packed {
        logic        wr;
        logic [2:0]  ctrl;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_wr;
    logic [2:0]  req_ctrl;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        busy;

    int   compared;
    int   mismatched;
    int   rsp_count;
    bit   last_accepted;
    vec_t vecs[$];
    exp_t exp_q[$];

    dmem_wait_responder #(
        .DEPTH_WORDS(DEPTH),
        .WAIT_CYCLES(WAITS)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_wr    (req_wr),
        .req_ctrl  (req_ctrl),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .busy      (busy)
    );

    // Free-running clock, rising edges at 5, 15, 25 ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Count completed response handshakes as the DUT sees them at the edge
    always @(posedge clk) begin
        if (rst_n && rsp_valid && rsp_ready) begin
            rsp_count <= rsp_count + 1;
        end
    end

    // Hard stop in case something hangs outside the bounded waits
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic compareValue(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic addVec(input logic wr, input logic [2:0] ctrl, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [31:0] exp_rdata, input logic exp_err);
        vec_t v;
        v.wr        = wr;
        v.ctrl      = ctrl;
        v.addr      = addr;
        v.wdata     = wdata;
        v.exp_rdata = exp_rdata;
        v.exp_err   = exp_err;
        vecs.push_back(v);
    endtask

    // Present a request from a falling edge and wait (bounded) for acceptance;
    // the expected response is queued when the request is accepted.
    task automatic applyStimulus(input string name, input logic wr, input logic [2:0] ctrl,
                                 input logic [31:0] addr, input logic [31:0] wdata,
                                 input logic [31:0] exp_rdata, input logic exp_err, input bit track);
        exp_t e;
        last_accepted = 1'b0;
        req_valid = 1'b1;
        req_wr    = wr;
        req_ctrl  = ctrl;
        req_addr  = addr;
        req_wdata = wdata;
        for (int i = 0; i < 32; i++) begin
            if (req_ready) begin
                last_accepted = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!last_accepted) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL %s accept: got req_ready=0 for 32 cycles, expected acceptance", name);
            req_valid = 1'b0;
            return;
        end
        if (track) begin
            e.rdata = exp_rdata;
            e.err   = exp_err;
            exp_q.push_back(e);
        end
        @(negedge clk);
        req_valid = 1'b0;
        req_wdata = 32'h0;
    endtask

    // Wait for the response, compare against the scoreboard, optionally hold it
    // under backpressure (with an ignored request pulse), then take it.
    task automatic checkOutput(input string name, input int hold, input bit pulse);
        int          lat;
        exp_t        e;
        logic [31:0] held;
        lat = 1;
        while (!rsp_valid && lat < 64) begin
            @(negedge clk);
            lat++;
        end
        if (!rsp_valid) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL %s response: got rsp_valid=0 after 64 cycles, expected a response", name);
            return;
        end
        compareValue({name, " latency"}, lat, WAITS + 2);
        compareValue({name, " busy"}, {31'd0, busy}, 32'd1);
        if (exp_q.size() == 0) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL %s scoreboard: got a response, expected none", name);
        end else begin
            e = exp_q.pop_front();
            compareValue({name, " rdata"}, rsp_rdata, e.rdata);
            compareValue({name, " err"}, {31'd0, rsp_err}, {31'd0, e.err});
        end
        held = rsp_rdata;
        for (int h = 0; h < hold; h++) begin
            if (pulse && h == 1) begin
                req_valid = 1'b1;
                req_wr    = 1'b1;
                req_ctrl  = F_W;
                req_addr  = 32'h10;
                req_wdata = 32'hFFFF_FFFF;
            end
            @(negedge clk);
            req_valid = 1'b0;
            compareValue($sformatf("%s hold%0d valid", name, h), {31'd0, rsp_valid}, 32'd1);
            compareValue($sformatf("%s hold%0d rdata", name, h), rsp_rdata, held);
            compareValue($sformatf("%s hold%0d req_ready", name, h), {31'd0, req_ready}, 32'd0);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        compareValue({name, " taken valid"}, {31'd0, rsp_valid}, 32'd0);
        compareValue({name, " taken req_ready"}, {31'd0, req_ready}, 32'd1);
    endtask

    initial begin
        int base_count;
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_wr    = 1'b0;
        req_ctrl  = 3'b000;
        req_addr  = 32'h0;
        req_wdata = 32'h0;
        rsp_ready = 1'b0;
        compared  = 0;
        mismatched = 0;
        rsp_count = 0;

        // Vector table
        addVec(1'b1, F_W,  32'h10, 32'hDEAD_BEEF, 32'h0000_0000, 1'b0);
        addVec(1'b0, F_B,  32'h13, 32'h0,         32'hFFFF_FFDE, 1'b0);
        addVec(1'b0, F_BU, 32'h13, 32'h0,         32'h0000_00DE, 1'b0);
        addVec(1'b0, F_H,  32'h10, 32'h0,         32'hFFFF_BEEF, 1'b0);
        addVec(1'b0, F_HU, 32'h12, 32'h0,         32'h0000_DEAD, 1'b0);
        addVec(1'b1, F_B,  32'h11, 32'hAAAA_AA55, 32'h0000_0000, 1'b0);
        addVec(1'b0, F_W,  32'h10, 32'h0,         32'hDEAD_55EF, 1'b0);
`ifdef DMEM_RSP_ALIGN_CHECK_EN
        addVec(1'b0, F_W,  32'h12, 32'h0,         32'h0000_0000, 1'b1);
`else
        addVec(1'b0, F_W,  32'h12, 32'h0,         32'hDEAD_55EF, 1'b0);
`endif
        addVec(1'b1, F_W,  32'h00, 32'h0BAD_F00D, 32'h0000_0000, 1'b0);
        addVec(1'b1, F_W,  32'(DEPTH * 4), 32'hFFFF_FFFF, 32'h0000_0000, 1'b1);
        addVec(1'b0, F_W,  32'h00, 32'h0,         32'h0BAD_F00D, 1'b0);
        addVec(1'b0, 3'b011, 32'h10, 32'h0,       32'h0000_0000, 1'b1);
        addVec(1'b0, 3'b110, 32'h10, 32'h0,       32'h0000_0000, 1'b1);
        addVec(1'b1, F_BU, 32'h10, 32'h0000_0077, 32'h0000_0000, 1'b1);
        addVec(1'b0, F_W,  32'h10, 32'h0,         32'hDEAD_55EF, 1'b0);
        addVec(1'b0, F_W,  32'h8000_0000, 32'h0,  32'h0000_0000, 1'b1);
        addVec(1'b1, F_W,  32'h14, 32'h1122_3344, 32'h0000_0000, 1'b0);
        addVec(1'b1, F_H,  32'h16, 32'h5678_CAFE, 32'h0000_0000, 1'b0);
        addVec(1'b0, F_W,  32'h14, 32'h0,         32'hCAFE_3344, 1'b0);
        addVec(1'b0, F_H,  32'h16, 32'h0,         32'hFFFF_CAFE, 1'b0);
        addVec(1'b0, F_B,  32'h15, 32'h0,         32'h0000_0033, 1'b0);
`ifdef DMEM_RSP_ALIGN_CHECK_EN
        addVec(1'b1, F_H,  32'h15, 32'h0000_BEEF, 32'h0000_0000, 1'b1);
        addVec(1'b0, F_W,  32'h14, 32'h0,         32'hCAFE_3344, 1'b0);
`else
        addVec(1'b1, F_H,  32'h15, 32'h0000_BEEF, 32'h0000_0000, 1'b0);
        addVec(1'b0, F_W,  32'h14, 32'h0,         32'hCAFE_BEEF, 1'b0);
`endif
        addVec(1'b0, F_B,  32'h16, 32'h0,         32'hFFFF_FFFE, 1'b0);
        addVec(1'b0, F_BU, 32'h17, 32'h0,         32'h0000_00CA, 1'b0);

        // Reset values while rst_n is held low
        @(negedge clk);
        compareValue("reset req_ready", {31'd0, req_ready}, 32'd0);
        compareValue("reset rsp_valid", {31'd0, rsp_valid}, 32'd0);
        compareValue("reset rsp_rdata", rsp_rdata, 32'd0);
        compareValue("reset rsp_err", {31'd0, rsp_err}, 32'd0);
        compareValue("reset busy", {31'd0, busy}, 32'd0);
        rst_n = 1'b1;
        #1;
        compareValue("release req_ready before edge", {31'd0, req_ready}, 32'd0);
        @(negedge clk);
        compareValue("release req_ready after edge", {31'd0, req_ready}, 32'd1);

        // Table-driven transactions
        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus($sformatf("vec%0d", i), vecs[i].wr, vecs[i].ctrl, vecs[i].addr,
                          vecs[i].wdata, vecs[i].exp_rdata, vecs[i].exp_err, 1'b1);
            if (last_accepted) begin
                checkOutput($sformatf("vec%0d", i), 0, 1'b0);
            end
        end

        // Backpressure: response held for 5 cycles, a store pulse in between is ignored
        applyStimulus("bp", 1'b0, F_W, 32'h10, 32'h0, 32'hDEAD_55EF, 1'b0, 1'b1);
        if (last_accepted) begin
            checkOutput("bp", 5, 1'b1);
        end
        repeat (6) @(negedge clk);
        compareValue("bp no extra response", {31'd0, rsp_valid}, 32'd0);
        applyStimulus("bp reread", 1'b0, F_W, 32'h10, 32'h0, 32'hDEAD_55EF, 1'b0, 1'b1);
        if (last_accepted) begin
            checkOutput("bp reread", 0, 1'b0);
        end

        // Reset in WAIT aborts a pending store with no write and no response
        applyStimulus("pre", 1'b1, F_W, 32'h20, 32'hA0A0_A0A0, 32'h0, 1'b0, 1'b1);
        if (last_accepted) begin
            checkOutput("pre", 0, 1'b0);
        end
        base_count = rsp_count;
        applyStimulus("abort", 1'b1, F_W, 32'h20, 32'h1234_5678, 32'h0, 1'b0, 1'b0);
        rst_n = 1'b0;
        #1;
        compareValue("abort busy", {31'd0, busy}, 32'd0);
        compareValue("abort req_ready", {31'd0, req_ready}, 32'd0);
        compareValue("abort rsp_valid", {31'd0, rsp_valid}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        compareValue("abort no response", {31'd0, rsp_valid}, 32'd0);
        applyStimulus("post", 1'b0, F_W, 32'h20, 32'h0, 32'hA0A0_A0A0, 1'b0, 1'b1);
        if (last_accepted) begin
            checkOutput("post", 0, 1'b0);
        end
        compareValue("abort response count", 32'(rsp_count - base_count), 32'd1);

        compareValue("scoreboard empty", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
